// File: rtl/wallace_mul_arbiter.sv
// Round-robin sequencer that shares one combinational multiplier between
// two requesters and returns each product over a valid/ready channel.
module wallace_mul_arbiter #(
   parameter int WIDTH   = 8,
   parameter int MUL_LAT = 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_req0_valid,
   output logic               o_req0_ready,
   input  logic [WIDTH-1:0]   i_req0_a,
   input  logic [WIDTH-1:0]   i_req0_b,
   input  logic               i_req1_valid,
   output logic               o_req1_ready,
   input  logic [WIDTH-1:0]   i_req1_a,
   input  logic [WIDTH-1:0]   i_req1_b,
   output logic [WIDTH-1:0]   o_mul_a,
   output logic [WIDTH-1:0]   o_mul_b,
   input  logic [2*WIDTH-1:0] i_mul_p,
   output logic               o_rsp_valid,
   input  logic               i_rsp_ready,
   output logic               o_rsp_id,
   output logic [2*WIDTH-1:0] o_rsp_product,
   output logic               o_busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [3:0] LAT_M1 = 4'(MUL_LAT - 1);

   logic [1:0]         r_state;
   logic [3:0]         r_cnt;
   logic               r_last;
   logic [WIDTH-1:0]   r_mul_a;
   logic [WIDTH-1:0]   r_mul_b;
   logic               r_rsp_valid;
   logic               r_rsp_id;
   logic [2*WIDTH-1:0] r_rsp_product;

   logic w_idle;
   logic w_gnt0;
   logic w_gnt1;
   logic w_hs;

   // On a tie the requester that did not win last time is granted.
   assign w_idle = (r_state == S_IDLE);
   assign w_gnt0 = i_req0_valid & (~i_req1_valid | r_last);
   assign w_gnt1 = i_req1_valid & (~i_req0_valid | ~r_last);
   assign w_hs   = w_idle & (w_gnt0 | w_gnt1);

   assign o_req0_ready  = w_idle & w_gnt0;
   assign o_req1_ready  = w_idle & w_gnt1;
   assign o_mul_a       = r_mul_a;
   assign o_mul_b       = r_mul_b;
   assign o_rsp_valid   = r_rsp_valid;
   assign o_rsp_id      = r_rsp_id;
   assign o_rsp_product = r_rsp_product;
   assign o_busy        = ~w_idle;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_last        <= 1'b1;
         r_mul_a       <= '0;
         r_mul_b       <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_id      <= 1'b0;
         r_rsp_product <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_hs) begin
                  r_mul_a  <= w_gnt1 ? i_req1_a : i_req0_a;
                  r_mul_b  <= w_gnt1 ? i_req1_b : i_req0_b;
                  r_rsp_id <= w_gnt1;
                  r_last   <= w_gnt1;
                  r_cnt    <= LAT_M1;
                  r_state  <= S_MUL;
               end
            end
            S_MUL: begin
               if (r_cnt == 4'd0) begin
                  r_rsp_product <= i_mul_p;
                  r_rsp_valid   <= 1'b1;
                  r_state       <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Bench for wallace_mul_arbiter: vector table, scoreboard, corner sequences
// and a second instance built with a three-cycle settle time.
module tb_wallace_mul_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        r0v = 0, r1v = 0, rsp_ready = 1;
   logic [7:0]  r0a = 0, r0b = 0, r1a = 0, r1b = 0;
   logic        r0r, r1r, rsp_valid, rsp_id, busy;
   logic [7:0]  mul_a, mul_b;
   logic [15:0] mul_p, rsp_product;

   logic        v3 = 0, r3, rv3, id3, busy3, z3r, glitch = 0;
   logic [7:0]  a3 = 0, b3 = 0, ma3, mb3;
   logic [15:0] mp3, rp3;
   logic        zero = 1'b0;
   logic [7:0]  zb = 8'd0;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit          id;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
   } vec_t;
   vec_t vec[6];

   typedef struct {
      bit          id;
      logic [15:0] p;
   } exp_t;
   exp_t sb[$];
   bit   gnt_log[$];

   always #5 clk = ~clk;

   assign mul_p = 16'(mul_a) * 16'(mul_b);
   assign mp3   = glitch ? 16'hDEAD : 16'(ma3) * 16'(mb3);

   wallace_mul_arbiter #(.WIDTH(8), .MUL_LAT(1)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req0_valid(r0v), .o_req0_ready(r0r),
      .i_req0_a(r0a), .i_req0_b(r0b),
      .i_req1_valid(r1v), .o_req1_ready(r1r),
      .i_req1_a(r1a), .i_req1_b(r1b),
      .o_mul_a(mul_a), .o_mul_b(mul_b), .i_mul_p(mul_p),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_id(rsp_id), .o_rsp_product(rsp_product),
      .o_busy(busy)
   );

   wallace_mul_arbiter #(.WIDTH(8), .MUL_LAT(3)) dut3 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req0_valid(v3), .o_req0_ready(r3),
      .i_req0_a(a3), .i_req0_b(b3),
      .i_req1_valid(zero), .o_req1_ready(z3r),
      .i_req1_a(zb), .i_req1_b(zb),
      .o_mul_a(ma3), .o_mul_b(mb3), .i_mul_p(mp3),
      .o_rsp_valid(rv3), .i_rsp_ready(1'b1),
      .o_rsp_id(id3), .o_rsp_product(rp3),
      .o_busy(busy3)
   );

   task automatic chk(input string name, input logic [39:0] act,
                      input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: push on observed handshake, pop on observed response.
   always @(negedge clk) begin
      if (rst_n) begin
         if (r0v && r0r) begin
            sb.push_back('{1'b0, 16'(r0a) * 16'(r0b)});
            gnt_log.push_back(1'b0);
         end
         if (r1v && r1r) begin
            sb.push_back('{1'b1, 16'(r1a) * 16'(r1b)});
            gnt_log.push_back(1'b1);
         end
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 40'd1, 40'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_rsp", {rsp_id, rsp_product}, {e.id, e.p});
            end
         end
      end
   end

   always @(negedge rst_n) sb.delete();

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid && n < 20) begin
         step();
         n++;
      end
      if (!rsp_valid) chk("rsp_timeout", 40'd0, 40'd1);
   endtask

   task automatic wait_ready(input bit id);
      int n = 0;
      @(negedge clk);
      while (!(id ? r1r : r0r) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("ready_timeout", 40'd0, 40'd1);
   endtask

   task automatic check_reset_vals(input string name);
      chk(name, {mul_a, mul_b, rsp_product, rsp_valid, rsp_id, busy},
          {8'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0});
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      step();
      rsp_ready = 1;
      if (v.id) begin r1v = 1; r1a = v.a; r1b = v.b; end
      else      begin r0v = 1; r0a = v.a; r0b = v.b; end
      wait_ready(v.id);
      chk("grant_excl", {r0r, r1r}, v.id ? 2'b01 : 2'b10);
      step();
      r0v = 0;
      r1v = 0;
      chk("issue", {mul_a, mul_b, busy, r0r, r1r, rsp_valid},
          {v.a, v.b, 1'b1, 1'b0, 1'b0, 1'b0});
      wait_rsp(n);
      chk("lat1", 40'(n), 40'd1);
      chk("rsp", {rsp_id, rsp_product, busy}, {v.id, v.p, 1'b1});
      step();
      chk("done", {rsp_valid, busy}, 2'b00);
   endtask

   initial begin
      int   n;
      logic id_hold;
      vec[0] = '{1'b0, 8'd13,  8'd11,  16'd143};
      vec[1] = '{1'b1, 8'd255, 8'd255, 16'd65025};
      vec[2] = '{1'b0, 8'd0,   8'd200, 16'd0};
      vec[3] = '{1'b1, 8'd1,   8'd255, 16'd255};
      vec[4] = '{1'b0, 8'd128, 8'd2,   16'd256};
      vec[5] = '{1'b1, 8'd200, 8'd100, 16'd20000};

      #2;
      check_reset_vals("reset_async");
      #10 rst_n = 1;
      @(negedge clk);
      check_reset_vals("reset_idle");
      chk("reset_ready", {r0r, r1r}, 2'b00);

      foreach (vec[i]) run_vec(vec[i]);

      // Valid withdrawn before a handshake could happen.
      @(negedge clk);
      r0v = 1; r0a = 8'd9; r0b = 8'd9;
      #1 r0v = 0;
      step();
      chk("no_grant", {busy, mul_a}, {1'b0, 8'd200});

      // Tie held for four transactions.
      rst_n = 0; #2 rst_n = 1;
      gnt_log.delete();
      r0a = 8'd3; r0b = 8'd4; r1a = 8'd5; r1b = 8'd6;
      r0v = 1; r1v = 1; rsp_ready = 1;
      n = 0;
      while (gnt_log.size() < 4 && n < 40) begin
         step();
         n++;
      end
      r0v = 0; r1v = 0;
      repeat (4) step();
      chk("tie_count", 40'(gnt_log.size()), 40'd4);
      for (int i = 0; i < 4 && i < gnt_log.size(); i++)
         chk("tie_order", 40'(gnt_log[i]), 40'(i % 2));

      // Backpressure hold.
      rsp_ready = 0;
      r0v = 1; r0a = 8'd7; r0b = 8'd9;
      wait_ready(1'b0);
      step();
      r0v = 0;
      r1v = 1;
      wait_rsp(n);
      id_hold = rsp_id;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold", {rsp_valid, rsp_id, rsp_product, r0r, r1r, busy},
             {1'b1, 1'b0, 16'd63, 1'b0, 1'b0, 1'b1});
      end
      step();
      rsp_ready = 1;
      r1v = 0;
      step();
      chk("bp_release", {rsp_valid, busy, id_hold}, 3'b000);

      // Reset while waiting on the multiplier.
      r1v = 1; r1a = 8'd10; r1b = 8'd10;
      wait_ready(1'b1);
      step();
      r1v = 0;
      chk("in_mul", busy, 1'b1);
      rst_n = 0;
      #1 check_reset_vals("rst_in_mul");
      @(negedge clk) rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("no_rsp_mul", {rsp_valid, busy}, 2'b00);
      end

      // Reset while holding a response.
      rsp_ready = 0;
      r0v = 1; r0a = 8'd20; r0b = 8'd30;
      wait_ready(1'b0);
      step();
      r0v = 0;
      wait_rsp(n);
      step();
      rst_n = 0;
      #1 check_reset_vals("rst_in_resp");
      @(negedge clk) rst_n = 1;
      rsp_ready = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("no_rsp_resp", {rsp_valid, busy}, 2'b00);
      end

      // First tie after reset goes to requester 0.
      r0a = 8'd2; r0b = 8'd3; r1a = 8'd4; r1b = 8'd5;
      r0v = 1; r1v = 1;
      @(negedge clk);
      chk("tie_after_rst", {r0r, r1r}, 2'b10);
      step();
      r0v = 0; r1v = 0;
      repeat (3) step();

      // Three-cycle settle with a glitching product before capture.
      v3 = 1; a3 = 8'd17; b3 = 8'd19;
      @(negedge clk);
      chk("l3_ready", r3, 1'b1);
      step();
      v3 = 0;
      a3 = 8'd1;
      glitch = 1;
      chk("l3_issue", {ma3, mb3, busy3, rv3}, {8'd17, 8'd19, 1'b1, 1'b0});
      step();
      chk("l3_t1", rv3, 1'b0);
      step();
      chk("l3_t2", rv3, 1'b0);
      glitch = 0;
      step();
      chk("l3_capture", {rv3, id3, rp3}, {1'b1, 1'b0, 16'd323});
      step();
      chk("l3_done", {rv3, busy3}, 2'b00);

      chk("sb_empty", 40'(sb.size()), 40'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wallace_mul_arbiter.md
# wallace_mul_arbiter

Sequencer/arbiter that shares one combinational 8x8 Wallace-tree multiplier between two requesters. It registers the winning operand pair onto the multiplier inputs and waits a fixed settle time. It then captures the product and returns it with the requester ID over a valid/ready response channel. It sits between the multiplier core (built from the half/full adder cells) and its clients.

## Interface
- WIDTH, 8: operand width; product is 2*WIDTH.
- MUL_LAT, 1: settle cycles allowed for the combinational multiplier (range 1-15).

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req1_valid  in  1  requester 1 has operands.
- req1_ready  out  1  requester 1 accepted this cycle.
- req1_a, req1_b  in  WIDTH  requester 1 operands.
- mul_a, mul_b  out  WIDTH  registered operands driving the shared multiplier.
- mul_p  in  2*WIDTH  product from the shared multiplier.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that owns the response.
- rsp_product  out  2*WIDTH  captured product.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - MUL: waiting for the multiplier to settle.
  - RESP: holding the response.
- IDLE:
  - reqN_ready is combinational: high only in IDLE, and only for the granted requester.
  - If exactly one valid is high, grant that requester.
  - If both are high, grant the requester opposite last_grant (round-robin).
  - On the handshake edge:
    - mul_a/mul_b <= winner operands.
    - rsp_id <= winner.
    - last_grant <= winner.
    - settle counter <= MUL_LAT-1.
    - State -> MUL.
- MUL:
  - Both readys are low.
  - Counter decrements each cycle.
  - On the edge where counter==0: rsp_product <= mul_p, rsp_valid <= 1, state -> RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_product are held stable until rsp_ready.
  - On the edge with rsp_valid && rsp_ready: rsp_valid <= 0, state -> IDLE.
- mul_a/mul_b hold their last values outside the issue edge; they are not cleared after a transaction.
- Arithmetic: the block performs none. rsp_product is mul_p verbatim, unsigned, 2*WIDTH bits.
- Reset (asynchronous, any state, including mid-transaction):
  - State IDLE.
  - mul_a, mul_b, rsp_product = 0.
  - rsp_valid, rsp_id = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - busy = 0.
  - An in-flight transaction is dropped with no response.
- Valid deasserted in IDLE before the handshake: no grant, no state change.
- Operands are sampled only on the handshake edge. Changes while not ready are ignored.

## Timing
- Issue: handshake edge T0. mul_a/mul_b are valid after T0.
- Capture edge: T0+MUL_LAT. rsp_valid is high after that edge.
  - With MUL_LAT=1, rsp_valid rises one cycle after acceptance.
- Response completes on the first edge with rsp_ready high. The next request can be accepted on the following edge at the earliest.
- Peak throughput: one product per MUL_LAT+2 cycles, i.e. 3 cycles at default.
- No combinational path from req*_valid to rsp_*, or from rsp_ready to req*_ready.
- busy = (state != IDLE), registered-state derived.

## Test plan
- Single op: reset, req0 with a=13, b=11, multiplier model connected, rsp_ready=1. Required:
  - req0_ready=1 for one cycle.
  - mul_a=13, mul_b=11.
  - rsp_valid rises 1 cycle later with rsp_product=143, rsp_id=0.
  - busy high for 2 cycles.
- Max operands: req1 with a=255, b=255. Required: rsp_product=65025, rsp_id=1.
- Simultaneous: both valid held for 4 transactions, req0 3*4 and req1 5*6. Required:
  - Grants 0,1,0,1.
  - Products 12,30,12,30.
  - No requester granted twice in a row.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid. Required:
  - rsp_valid, rsp_id and rsp_product stable throughout.
  - Both readys low.
  - Return to IDLE one edge after rsp_ready=1.
- MUL_LAT=3: capture occurs 3 edges after acceptance. mul_p glitching before the capture edge must not affect rsp_product.
- Reset mid-op: assert rst_n=0 in MUL, then in RESP. Required:
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - No response is emitted.
  - The first tie after reset is granted to requester 0.
